// File: rtl/coloring_seq_checker.sv
// coloring_seq_checker: flags forbidden adjacent colour pairs and over-long identical-colour runs
// Ports: clk, rst_n (sync active-low), in_valid/color (token in), clear (soft clear),
//        check (registered violation flag), run_cnt, last_color, err_cnt (saturating).
// Optional macro STICKY_CHECK_EN: check holds at 1 after the first violation until reset/clear.
module coloring_seq_checker #(
    parameter int COLOR_W    = 2,
    parameter int NUM_COLORS = 3,
    parameter int RUN_LEN    = 3,
    parameter logic [NUM_COLORS*NUM_COLORS-1:0] FORBID = 9'h00A,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [COLOR_W-1:0]           color,
    input  logic                         clear,
    output logic                         check,
    output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
    output logic [COLOR_W-1:0]           last_color,
    output logic [CNT_W-1:0]             err_cnt
);
    localparam int RUN_W = $clog2(RUN_LEN+1);
    localparam int IDX_W = (NUM_COLORS*NUM_COLORS > 1) ? $clog2(NUM_COLORS*NUM_COLORS) : 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;
    localparam logic [COLOR_W:0] NC = NUM_COLORS[COLOR_W:0];
    localparam logic [RUN_W-1:0] RL = RUN_LEN[RUN_W-1:0];
    localparam logic [RUN_W-1:0] RL1 = RL - 1'b1;
    localparam logic [IDX_W-1:0] NCI = NUM_COLORS[IDX_W-1:0];
    logic [0:0] state;
    logic tok, same, hit, viol, check_d;
    logic [IDX_W-1:0] idx;
    logic [RUN_W-1:0] run_nxt;
    assign tok  = in_valid && ({1'b0, color} < NC);
    assign same = color == last_color;
    // run_cnt+1 >= RUN_LEN, rewritten so run_cnt+1 can never overflow RUN_W bits
    assign hit  = run_cnt >= RL1;
    assign run_nxt = hit ? RL : run_cnt + 1'b1;
    assign idx  = IDX_W'(last_color) * NCI + IDX_W'(color);
    assign viol = tok && state == TRACK && ((same && hit) || FORBID[idx]);
`ifdef STICKY_CHECK_EN
    assign check_d = check | viol;
`else
    assign check_d = viol;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= EMPTY;
            check      <= 1'b0;
            run_cnt    <= '0;
            last_color <= '0;
            err_cnt    <= '0;
        end else begin
            check <= check_d;
            if (viol && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (tok) begin
                state      <= TRACK;
                last_color <= color;
                run_cnt    <= (state == TRACK && same) ? run_nxt : RUN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_coloring_seq_checker.sv
// tb_coloring_seq_checker: directed self-checking bench for coloring_seq_checker
module tb_coloring_seq_checker;
    logic clk = 1'b0;
    logic rst_n, in_valid, clear;
    logic [1:0] color;
    logic check, check2;
    logic [1:0] run_cnt, run_cnt2, last_color, last_color2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    coloring_seq_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .color(color), .clear(clear),
        .check(check), .run_cnt(run_cnt), .last_color(last_color), .err_cnt(err_cnt)
    );

    coloring_seq_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .color(color), .clear(clear),
        .check(check2), .run_cnt(run_cnt2), .last_color(last_color2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic clr);
        @(negedge clk);
        rst_n = r; in_valid = v; color = c; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic tok(input logic [1:0] c);
        step(1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; color = 2'd0; clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 2'd0, 1'b0);
            chk("rst_check", check, 0);
            chk("rst_run", run_cnt, 0);
            chk("rst_last", last_color, 0);
            chk("rst_err", err_cnt, 0);
        end
        tok(0); chk("run1_check", check, 0); chk("run1_cnt", run_cnt, 1);
        tok(0); chk("run2_check", check, 0); chk("run2_cnt", run_cnt, 2);
        tok(0); chk("run3_check", check, 1); chk("run3_cnt", run_cnt, 3);
        tok(0); chk("run4_check", check, 1); chk("run4_cnt", run_cnt, 3);
        chk("run_err", err_cnt, 2);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("idle_check", check, 0); chk("idle_err", err_cnt, 2); chk("idle_run", run_cnt, 3);

        do_clear();
        chk("clr_err", err_cnt, 0); chk("clr_run", run_cnt, 0);
        tok(0); chk("pair0_check", check, 0);
        tok(1); chk("pair01_check", check, 1); chk("pair01_last", last_color, 1);
        tok(2); chk("pair12_check", check, 0);
        tok(0); chk("pair20_check", check, 0); chk("pair20_run", run_cnt, 1);
        chk("pair_err", err_cnt, 1);
        tok(1); chk("pair01b_check", check, 1);
        tok(0); chk("pair10_check", check, 1); chk("pair_err2", err_cnt, 3);

        do_clear();
        tok(2); chk("ill_a_check", check, 0);
        tok(3); chk("ill_b_check", check, 0); chk("ill_b_last", last_color, 2); chk("ill_b_run", run_cnt, 1);
        step(1'b1, 1'b0, 2'd2, 1'b0); chk("ill_idle_check", check, 0);
        tok(2); chk("ill_c_check", check, 0); chk("ill_c_run", run_cnt, 2);
        tok(2); chk("ill_d_check", check, 1); chk("ill_d_run", run_cnt, 3);

        do_clear();
        tok(0); tok(0);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        chk("clrp_run", run_cnt, 0); chk("clrp_check", check, 0); chk("clrp_err", err_cnt, 0);
        tok(0);
        chk("clrp_tok_run", run_cnt, 1); chk("clrp_tok_check", check, 0); chk("clrp_tok_err", err_cnt, 0);

        tok(2); tok(2);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        chk("midrst_run", run_cnt, 0); chk("midrst_last", last_color, 0);
        tok(2); chk("midrst_tok_run", run_cnt, 1); chk("midrst_tok_check", check, 0);

        do_clear();
        for (int i = 1; i <= 10; i++) begin
            tok(1);
            if (i == 5) chk("sat5_err2", err_cnt2, 3);
        end
        chk("sat_err2", err_cnt2, 3); chk("sat_err", err_cnt, 8);
        chk("sat_check2", check2, 1); chk("sat_run", run_cnt, 3);

`ifdef STICKY_CHECK_EN
        do_clear();
        tok(0); tok(1); chk("sticky_a", check, 1);
        tok(2); chk("sticky_b", check, 1);
        tok(2); chk("sticky_c", check, 1); chk("sticky_err", err_cnt, 1);
        do_clear(); chk("sticky_clr", check, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
